// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and the Controller vector for EX,
// with freeze, hazard bubbles, branch flush (deferred across freeze) and saturating debug counters.
module id_ex_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic             valid_in,
  input  logic [8:0]       controllerRes,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  input  logic             imm,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm_24,
  input  logic [3:0]       dest,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic [3:0]       status_in,
  output logic [3:0]       exe_cmd_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             wb_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] val_rn_out,
  output logic [WIDTH-1:0] val_rm_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm_24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       status_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             flush_pending
);

  localparam int DW = 3 * WIDTH + 53;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_KILL   = 2'd1,
    MODE_BUBBLE = 2'd2,
    MODE_LOAD   = 2'd3
  } mode_e;

  mode_e            mode;
  logic [9:0]       ctrl_in;
  logic [DW-1:0]    data_in;
  logic [9:0]       ctrl_d, ctrl_q;
  logic [DW-1:0]    data_d, data_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             flush_pending_d, flush_pending_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Control group carries valid in its MSB so a NOP is simply ctrl == 0.
  assign ctrl_in = {valid_in, controllerRes};
  assign data_in = {pc_in, val_rn, val_rm, imm, shift_operand, signed_imm_24,
                    dest, src1, src2, status_in};

  always_comb begin
    if (freeze)                         mode = MODE_HOLD;
    else if (flush || flush_pending_q)  mode = MODE_KILL;
    else if (hazard)                    mode = MODE_BUBBLE;
    else                                mode = MODE_LOAD;
  end

  always_comb begin
    ctrl_d          = ctrl_q;
    data_d          = data_q;
    bubble_cnt_d    = bubble_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    flush_pending_d = flush_pending_q;
    case (mode)
      MODE_HOLD: begin
        // A flush seen while frozen is remembered so it cannot be lost.
        flush_pending_d = flush_pending_q | flush;
      end
      MODE_KILL: begin
        ctrl_d          = '0;
        data_d          = data_in;
        flush_pending_d = 1'b0;
        flush_cnt_d     = sat_inc(flush_cnt_q);
      end
      MODE_BUBBLE: begin
        ctrl_d       = '0;
        data_d       = data_in;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      default: begin
        ctrl_d = valid_in ? ctrl_in : '0;
        data_d = data_in;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q          <= '0;
      data_q          <= '0;
      bubble_cnt_q    <= '0;
      flush_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      ctrl_q          <= ctrl_d;
      data_q          <= data_d;
      bubble_cnt_q    <= bubble_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign {valid_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out} = ctrl_q;
  assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
          dest_out, src1_out, src2_out, status_out} = data_q;
  assign bubble_cnt    = bubble_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign flush_pending = flush_pending_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural model of the capture rules.
module tb_id_ex_stage_reg;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int DW   = 3 * W + 53;
  localparam int EW   = 10 + DW + 2 * CW + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst, freeze, flush, hazard, valid_in;
  logic [8:0]    controllerRes;
  logic [W-1:0]  pc_in, val_rn, val_rm;
  logic          imm;
  logic [11:0]   shift_operand;
  logic [23:0]   signed_imm_24;
  logic [3:0]    dest, src1, src2, status_in;

  logic [3:0]    exe_cmd_out;
  logic          mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic [W-1:0]  pc_out, val_rn_out, val_rm_out;
  logic          imm_out;
  logic [11:0]   shift_operand_out;
  logic [23:0]   signed_imm_24_out;
  logic [3:0]    dest_out, src1_out, src2_out, status_out;
  logic          valid_out;
  logic [CW-1:0] bubble_cnt, flush_cnt;
  logic          flush_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [EW-1:0] act_vec;

  // Reference model state: what the outputs should be after the next edge.
  logic [9:0]    m_ctrl;
  logic [DW-1:0] m_data;
  int            m_bcnt, m_fcnt;
  bit            m_pend;

  id_ex_stage_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .valid_in(valid_in), .controllerRes(controllerRes),
    .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .dest(dest), .src1(src1), .src2(src2), .status_in(status_in),
    .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .valid_out(valid_out), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .flush_pending(flush_pending)
  );

  assign act_vec = {valid_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out,
                    pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
                    dest_out, src1_out, src2_out, status_out,
                    bubble_cnt, flush_cnt, flush_pending};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0;
    m_data = '0;
    m_bcnt = 0;
    m_fcnt = 0;
    m_pend = 0;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Driver: apply the capture rules to the current inputs, queue the result, advance one cycle.
  task automatic cycle();
    if (rst) begin
      model_reset();
    end else if (freeze) begin
      if (flush) m_pend = 1;
    end else begin
      m_data = {pc_in, val_rn, val_rm, imm, shift_operand, signed_imm_24,
                dest, src1, src2, status_in};
      if (flush || m_pend) begin
        m_ctrl = '0;
        m_pend = 0;
        m_fcnt = sat(m_fcnt + 1);
      end else if (hazard) begin
        m_ctrl = '0;
        m_bcnt = sat(m_bcnt + 1);
      end else begin
        m_ctrl = valid_in ? {1'b1, controllerRes} : 10'd0;
      end
    end
    exp_q.push_back({m_ctrl, m_data, m_bcnt[CW-1:0], m_fcnt[CW-1:0], m_pend});
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [8:0] cr, input logic [W-1:0] pc,
                           input logic [W-1:0] rn, input logic [W-1:0] rm, input logic [3:0] d);
    valid_in      = 1'b1;
    controllerRes = cr;
    pc_in         = pc;
    val_rn        = rn;
    val_rm        = rm;
    dest          = d;
    imm           = 1'b0;
    shift_operand = '0;
    signed_imm_24 = '0;
    src1          = '0;
    src2          = '0;
    status_in     = '0;
  endtask

  task automatic randomize_inputs();
    rst           = ($urandom_range(0, 59) == 0);
    freeze        = ($urandom_range(0, 9) < 2);
    flush         = ($urandom_range(0, 9) < 2);
    hazard        = ($urandom_range(0, 9) < 2);
    valid_in      = ($urandom_range(0, 9) < 8);
    controllerRes = 9'($urandom);
    pc_in         = $urandom;
    val_rn        = $urandom;
    val_rm        = $urandom;
    imm           = 1'($urandom);
    shift_operand = 12'($urandom);
    signed_imm_24 = 24'($urandom);
    dest          = 4'($urandom);
    src1          = 4'($urandom);
    src2          = 4'($urandom);
    status_in     = 4'($urandom);
  endtask

  // Monitor: outputs are presented every edge; compare against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("ctrl_group",    256'(act_vec[EW-1 -: 10]),       256'(mon_e[EW-1 -: 10]));
        check("data_group",    256'(act_vec[2*CW+1 +: DW]),     256'(mon_e[2*CW+1 +: DW]));
        check("bubble_cnt",    256'(act_vec[CW+1 +: CW]),       256'(mon_e[CW+1 +: CW]));
        check("flush_cnt",     256'(act_vec[1 +: CW]),          256'(mon_e[1 +: CW]));
        check("flush_pending", 256'(act_vec[0]),                256'(mon_e[0]));
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1; freeze = 1'b1; flush = 1'b1; hazard = 1'b1; valid_in = 1'b1;
    controllerRes = '1; pc_in = '1; val_rn = '1; val_rm = '1; imm = 1'b1;
    shift_operand = '1; signed_imm_24 = '1; dest = '1; src1 = '1; src2 = '1; status_in = '1;
    #1;
    check("reset valid_out", 256'(valid_out), 256'(0));
    check("reset pc_out", 256'(pc_out), 256'(0));
    check("reset bubble_cnt", 256'(bubble_cnt), 256'(0));
    cycle();
    cycle();

    // First edge after release is a normal capture with valid_in low
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0; valid_in = 1'b0;
    cycle();
    check("post-reset ctrl",
          256'({valid_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out}),
          256'(0));

    // LOAD
    set_instr(9'b0010_1_0_1_0_1, 32'h10, 32'd5, 32'd7, 4'd3);
    cycle();
    check("load exe_cmd", 256'(exe_cmd_out), 256'(4'b0010));
    check("load wb_en", 256'(wb_en_out), 256'(1));
    check("load s", 256'(s_out), 256'(1));
    check("load pc", 256'(pc_out), 256'(32'h10));
    check("load dest", 256'(dest_out), 256'(3));
    check("load valid", 256'(valid_out), 256'(1));

    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    check("async rst valid_out", 256'(valid_out), 256'(0));
    check("async rst pc_out", 256'(pc_out), 256'(0));
    check("async rst wb_en", 256'(wb_en_out), 256'(0));
    model_reset();
    cycle();
    rst = 1'b0;

    // Hazard bubble on a load-word
    set_instr({4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 32'h14, 32'd1, 32'd2, 4'd4);
    hazard = 1'b1;
    cycle();
    hazard = 1'b0;
    check("hazard mem_r_en", 256'(mem_r_en_out), 256'(0));
    check("hazard valid", 256'(valid_out), 256'(0));
    check("hazard pc", 256'(pc_out), 256'(32'h14));
    check("hazard bubble_cnt", 256'(bubble_cnt), 256'(1));

    // Freeze for 3 cycles with flush in the 2nd
    set_instr(9'b0100_0_0_1_0_0, 32'h20, 32'd9, 32'd8, 4'd5);
    cycle();
    freeze = 1'b1;
    pc_in  = 32'h24;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    check("freeze hold pc", 256'(pc_out), 256'(32'h20));
    check("freeze hold wb_en", 256'(wb_en_out), 256'(1));
    check("freeze pending", 256'(flush_pending), 256'(1));
    freeze = 1'b0;
    cycle();
    check("release valid", 256'(valid_out), 256'(0));
    check("release wb_en", 256'(wb_en_out), 256'(0));
    check("release flush_cnt", 256'(flush_cnt), 256'(1));
    check("release pending", 256'(flush_pending), 256'(0));
    check("release pc", 256'(pc_out), 256'(32'h24));

    // Flush during freeze plus another flush on the release edge counts once
    freeze = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    freeze = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("double flush cnt", 256'(flush_cnt), 256'(2));

    // Flush and hazard together
    flush = 1'b1; hazard = 1'b1;
    cycle();
    flush = 1'b0; hazard = 1'b0;
    check("simul flush_cnt", 256'(flush_cnt), 256'(3));
    check("simul bubble_cnt", 256'(bubble_cnt), 256'(1));
    check("simul wb_en", 256'(wb_en_out), 256'(0));

    // Counter saturation
    hazard = 1'b1;
    repeat (20) cycle();
    check("sat bubble_cnt", 256'(bubble_cnt), 256'(15));
    cycle();
    check("sat bubble_cnt hold", 256'(bubble_cnt), 256'(15));
    hazard = 1'b0;

    // A pending flush does not survive reset
    freeze = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("pre-reset pending", 256'(flush_pending), 256'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0; freeze = 1'b0;
    cycle();
    check("post-reset no kill valid", 256'(valid_out), 256'(1));
    check("post-reset flush_cnt", 256'(flush_cnt), 256'(0));

    // Random traffic
    repeat (400) begin
      randomize_inputs();
      cycle();
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
    cycle();

    @(posedge clk);
    #2;
    check("scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
